// File: rtl/fifo_uart_drain_pkg.sv
// Shared definitions for the FIFO-to-UART drain: FSM state encoding, UART frame
// constants and small helpers used by the top and the byte serialiser.
package fifo_uart_drain_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_REQ  = 4'd1,
        S_WAIT = 4'd2,
        S_SEND = 4'd3,
        S_DONE = 4'd4
    } state_e;

    localparam int FRAME_BITS     = 10;
    localparam int BYTES_PER_WORD = 4;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // 8N1 frame, transmitted from bit 0: start(0), data LSB first, stop(1)
    function automatic logic [FRAME_BITS-1:0] uart_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/fifo_uart_drain_uart_tx.sv
// UART 8N1 byte serialiser. ready rises in the last cycle of the stop bit so a
// start in that cycle chains the next frame without an idle gap.
module uart_tx_byte
    import fifo_uart_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic                  active_q, active_d;
    logic                  tx_q, tx_d;
    logic                  ready_q, ready_d;

    // next-state: load a frame on start, otherwise shift one bit per bit period
    always_comb begin
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        clk_cnt_d = clk_cnt_q;
        active_d  = active_q;
        tx_d      = tx_q;
        if (start && ready_q) begin
            frame_d   = uart_frame(data);
            bit_idx_d = 4'd0;
            clk_cnt_d = {CW{1'b0}};
            active_d  = 1'b1;
            tx_d      = 1'b0;
        end else if (active_q) begin
            if (clk_cnt_q == CNT_LAST) begin
                clk_cnt_d = {CW{1'b0}};
                if (bit_idx_q == BIT_LAST) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    frame_d   = {1'b1, frame_q[FRAME_BITS-1:1]};
                    tx_d      = frame_q[1];
                end
            end else begin
                clk_cnt_d = clk_cnt_q + CW'(1);
            end
        end else begin
            tx_d = 1'b1;
        end
        ready_d = !active_d || ((bit_idx_d == BIT_LAST) && (clk_cnt_d == CNT_LAST));
    end

    // state registers, line idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q   <= {FRAME_BITS{1'b1}};
            bit_idx_q <= 4'd0;
            clk_cnt_q <= {CW{1'b0}};
            active_q  <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
        end else begin
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            clk_cnt_q <= clk_cnt_d;
            active_q  <= active_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;

endmodule

// File: rtl/fifo_uart_drain.sv
// Drains 32-bit words from fifo_SRAM with a one-cycle read pulse and sends each
// as four back-to-back UART bytes, LSB byte first.
module fifo_uart_drain
    import fifo_uart_drain_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        empty,
    input  logic        busy,
    output logic        user_re,
    input  logic [31:0] data_in,
    input  logic        data_r_rdy,
    output logic        tx,
    output logic        tx_active,
    output logic [15:0] word_count,
    output logic        err
);

    localparam int             CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int             TMO_W        = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 2);

    state_e             state_q, state_d;
    logic [31:0]        word_q, word_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               user_re_q, user_re_d;
    logic               tx_active_q, tx_active_d;
    logic [15:0]        word_count_q, word_count_d;
    logic               err_q, err_d;
    logic               start_s;
    logic [7:0]         byte_s;
    logic               tx_ready_s;

    // FSM next-state; byte 0 is launched straight from S_WAIT so tx falls the next cycle
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        tmo_cnt_d    = tmo_cnt_q;
        user_re_d    = 1'b0;
        tx_active_d  = tx_active_q;
        word_count_d = word_count_q;
        err_d        = err_q;
        start_s      = 1'b0;
        byte_s       = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (enable && !empty && !busy) begin
                    state_d   = S_REQ;
                    user_re_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                tmo_cnt_d = {TMO_W{1'b0}};
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (data_r_rdy) begin
                    word_d      = data_in;
                    byte_idx_d  = 3'd1;
                    start_s     = 1'b1;
                    byte_s      = data_in[7:0];
                    tx_active_d = 1'b1;
                    state_d     = S_SEND;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_SEND: begin
                if (tx_ready_s) begin
                    if (byte_idx_q == 3'(BYTES_PER_WORD)) begin
                        tx_active_d = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        start_s    = 1'b1;
                        byte_s     = 8'(word_q >> {byte_idx_q[1:0], 3'b000});
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                word_count_d = word_count_q + 16'd1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            word_q       <= 32'd0;
            byte_idx_q   <= 3'd0;
            tmo_cnt_q    <= {TMO_W{1'b0}};
            user_re_q    <= 1'b0;
            tx_active_q  <= 1'b0;
            word_count_q <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            tmo_cnt_q    <= tmo_cnt_d;
            user_re_q    <= user_re_d;
            tx_active_q  <= tx_active_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .data  (byte_s),
        .tx    (tx),
        .ready (tx_ready_s)
    );

    assign user_re    = user_re_q;
    assign tx_active  = tx_active_q;
    assign word_count = word_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain at 4 clocks per UART bit, with a small
// fifo_SRAM model answering each read 3 cycles after user_re.
module tb_fifo_uart_drain;

    localparam int CPB      = 4;
    localparam int TIMEOUT  = 1024;
    localparam int WORD_CYC = 40 * CPB;
    localparam int RDY_LAT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        busy;
    logic        data_r_rdy = 1'b0;
    logic [31:0] data_in = 32'd0;
    wire         empty;
    wire         user_re;
    wire         tx;
    wire         tx_active;
    wire  [15:0] word_count;
    wire         err;

    logic [31:0] mem [32];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    bit          respond = 1'b1;
    int          cyc = 0;
    int          re_count = 0;
    int          re_last = 0;
    int          re_prev = 0;
    int          rdy_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    assign empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    fifo_uart_drain #(
        .CLK_FREQ (50_000_000),
        .BAUD     (12_500_000),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .empty      (empty),
        .busy       (busy),
        .user_re    (user_re),
        .data_in    (data_in),
        .data_r_rdy (data_r_rdy),
        .tx         (tx),
        .tx_active  (tx_active),
        .word_count (word_count),
        .err        (err)
    );

    // fifo_SRAM model: pop on user_re, strobe data_r_rdy for one cycle RDY_LAT cycles later
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            data_r_rdy = 1'b0;
            if (rdy_cnt > 0) begin
                rdy_cnt--;
                if (rdy_cnt == 0 && respond) data_r_rdy = 1'b1;
            end
            if (user_re === 1'b1) begin
                re_count++;
                re_prev = re_last;
                re_last = cyc;
                data_in = mem[rd_ptr % 32];
                rd_ptr++;
                rdy_cnt = RDY_LAT;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 32] = w;
        wr_ptr++;
    endtask

    // Wait for the start bit of byte 0, decode the 4 frames mid-bit, then check idle and count
    task automatic recv_word(input string tag, input logic [31:0] exp_word, input logic [15:0] exp_count);
        int          n;
        int          act;
        int          ferr;
        logic [31:0] got;
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check_eq({tag, "_start"}, 32'(tx === 1'b0), 32'd1);
        if (tx !== 1'b0) return;
        got  = 32'd0;
        act  = 0;
        ferr = 0;
        for (int k = 0; k < WORD_CYC; k++) begin
            if (tx_active === 1'b1) act++;
            if (k % CPB == 1) begin
                int b;
                int by;
                b  = (k % 40) / CPB;
                by = k / 40;
                if (b == 0) ferr += int'(tx !== 1'b0);
                else if (b == 9) ferr += int'(tx !== 1'b1);
                else got[by*8 + b - 1] = tx;
            end
            tick();
        end
        check_eq({tag, "_data"}, got, exp_word);
        check_eq({tag, "_framing"}, 32'(ferr), 32'd0);
        check_eq({tag, "_active_cycles"}, 32'(act), 32'(WORD_CYC));
        check_eq({tag, "_active_end"}, 32'(tx_active), 32'd0);
        check_eq({tag, "_tx_idle"}, 32'(tx), 32'd1);
        tick();
        check_eq({tag, "_count"}, 32'(word_count), 32'(exp_count));
    endtask

    initial begin
        int n;
        bit tx_low;

        // 1: reset values while rst held with a word waiting
        rst    = 1'b1;
        enable = 1'b1;
        busy   = 1'b0;
        push(32'hA55A0F01);
        tick();
        check_eq("t1_tx", 32'(tx), 32'd1);
        check_eq("t1_user_re", 32'(user_re), 32'd0);
        check_eq("t1_count", 32'(word_count), 32'd0);
        check_eq("t1_err", 32'(err), 32'd0);
        tick();
        check_eq("t1_tx2", 32'(tx), 32'd1);
        check_eq("t1_user_re2", 32'(user_re), 32'd0);
        check_eq("t1_active", 32'(tx_active), 32'd0);
        rst = 1'b0;

        // 2: single word, request issued the first cycle out of reset
        tick();
        check_eq("t2_req", 32'(user_re), 32'd1);
        recv_word("t2", 32'hA55A0F01, 16'd1);
        repeat (300) tick();
        check_eq("t2_one_pulse", 32'(re_count), 32'd1);

        // 3: empty then busy block requests
        tx_low = 1'b0;
        repeat (250) begin
            tick();
            tx_low |= (tx !== 1'b1);
        end
        busy = 1'b1;
        push(32'h3C3C00FF);
        repeat (250) begin
            tick();
            tx_low |= (tx !== 1'b1);
        end
        check_eq("t3_no_req", 32'(re_count), 32'd1);
        check_eq("t3_tx_quiet", 32'(tx_low), 32'd0);
        busy = 1'b0;
        recv_word("t3", 32'h3C3C00FF, 16'd2);

        // 4: read timeout, then normal drain with err still set
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("t4_count_rst", 32'(word_count), 32'd0);
        respond = 1'b0;
        push(32'hFFFFFFFF);
        n = 0;
        while (user_re !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq("t4_req", 32'(user_re), 32'd1);
        tx_low = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            tx_low |= (tx !== 1'b1);
        end
        check_eq("t4_err_early", 32'(err), 32'd0);
        tick();
        check_eq("t4_err_set", 32'(err), 32'd1);
        check_eq("t4_tx_quiet", 32'(tx_low), 32'd0);
        check_eq("t4_count", 32'(word_count), 32'd0);
        respond = 1'b1;
        push(32'h12345678);
        recv_word("t4", 32'h12345678, 16'd1);
        check_eq("t4_err_sticky", 32'(err), 32'd1);

        // 5: reset during data bit 3 of byte 2 (byte 0x25, bit 3 = 0)
        push(32'hDE25BEEF);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check_eq("t5_start", 32'(tx), 32'd0);
        repeat (97) tick();
        check_eq("t5_bit3", 32'(tx), 32'd0);
        rst = 1'b1;
        tick();
        check_eq("t5_tx_rst", 32'(tx), 32'd1);
        check_eq("t5_active_rst", 32'(tx_active), 32'd0);
        check_eq("t5_count_rst", 32'(word_count), 32'd0);
        check_eq("t5_err_rst", 32'(err), 32'd0);
        rst = 1'b0;
        push(32'hCAFEF00D);
        recv_word("t5", 32'hCAFEF00D, 16'd1);

        // 6: counter wrap with two back-to-back words
        force dut.word_count_q = 16'hFFFF;
        tick();
        release dut.word_count_q;
        tick();
        check_eq("t6_preload", 32'(word_count), 32'h0000FFFF);
        push(32'h80000001);
        push(32'h7E5AA5E7);
        recv_word("t6a", 32'h80000001, 16'h0000);
        recv_word("t6b", 32'h7E5AA5E7, 16'h0001);
        // one word on the line plus read latency plus S_DONE, S_IDLE and S_WAIT-entry cycles
        check_eq("t6_spacing", 32'(re_last - re_prev), 32'(WORD_CYC + RDY_LAT + 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
